// File: rtl/sw_array_sequencer.sv
// Sequencer for one parallel-load Smith-Waterman systolic array: loads the query, streams a
// target, tracks array latency and reports the best last-PE score with its target column.
module sw_array_sequencer #(
  parameter int unsigned NUM_PES       = 1000,
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned ARRAY_LATENCY = NUM_PES,
  parameter int unsigned COL_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NUM_PES-1:0] query_in,
  input  logic                 query_valid,
  output logic                 query_ready,
  input  logic [1:0]           t_in,
  input  logic                 t_valid,
  input  logic                 t_last,
  output logic                 t_ready,
  output logic [2*NUM_PES-1:0] S_out,
  output logic [1:0]           T_out,
  output logic                 store_S_out,
  output logic                 init_out,
  input  logic [WIDTH-1:0]     V_in,
  output logic [WIDTH-1:0]     score_out,
  output logic [COL_W-1:0]     score_col,
  output logic                 score_valid,
  input  logic                 score_ready,
  output logic                 err_underrun
);

  // The cycle counter must reach (max target length - 1) + ARRAY_LATENCY.
  localparam int unsigned CntW = $clog2((1 << COL_W) + ARRAY_LATENCY);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StReport} state_e;

  state_e                 state_q, state_d;
  logic [2*NUM_PES-1:0]   s_q, s_d;
  logic [1:0]             t_q, t_d;
  logic                   store_q, store_d;
  logic                   init_q, init_d;
  logic                   q_loaded_q, q_loaded_d;
  logic                   pend_q, pend_d;
  logic                   err_q, err_d;
  logic                   aborted_q, aborted_d;
  logic                   score_valid_q, score_valid_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [COL_W-1:0]       len_q, len_d;
  logic [WIDTH-1:0]       best_q, best_d;
  logic [COL_W-1:0]       best_col_q, best_col_d;

  logic                   t_acc, q_acc, first_acc, busy, sample, last_sample;
  logic [CntW-1:0]        lat_c, len_ext, col;

  assign lat_c   = CntW'(ARRAY_LATENCY);
  assign len_ext = CntW'(len_q);
  assign col     = cnt_q - lat_c;
  assign busy    = (state_q == StStream) || (state_q == StDrain);

  // A pending query takes priority over a target in IDLE.
  always_comb begin
    query_ready = rst & (state_q == StIdle);
    t_ready     = 1'b0;
    if (state_q == StIdle) begin
      t_ready = q_loaded_q & ~query_valid;
    end else if (state_q == StStream) begin
      t_ready = 1'b1;
    end
  end

  assign t_acc       = t_valid & t_ready;
  assign q_acc       = query_valid & query_ready;
  assign first_acc   = t_acc & (state_q == StIdle);
  // V_in carries column col once the array pipeline has filled.
  assign sample      = busy && (cnt_q >= lat_c) && (col < len_ext);
  assign last_sample = sample && (col == len_ext - CntW'(1));

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    t_d           = 2'b00;
    store_d       = 1'b0;
    init_d        = 1'b0;
    q_loaded_d    = q_loaded_q;
    pend_d        = pend_q;
    err_d         = err_q;
    aborted_d     = aborted_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    best_d        = best_q;
    best_col_d    = best_col_q;

    if (t_acc) begin
      t_d   = t_in;
      len_d = len_q + COL_W'(1);
    end

    if (first_acc) begin
      init_d    = 1'b1;
      store_d   = pend_q;
      pend_d    = 1'b0;
      cnt_d     = '0;
      len_d     = COL_W'(1);
      aborted_d = 1'b0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Strictly greater keeps the earliest column on ties.
    if (sample && ((col == '0) || (V_in > best_q))) begin
      best_d     = V_in;
      best_col_d = col[COL_W-1:0];
    end

    unique case (state_q)
      StIdle: begin
        if (q_acc) begin
          s_d        = query_in;
          q_loaded_d = 1'b1;
          pend_d     = 1'b1;
        end else if (t_acc) begin
          state_d = t_last ? StDrain : StStream;
        end
      end
      StStream: begin
        if (!t_valid) begin
          err_d     = 1'b1;
          aborted_d = 1'b1;
          state_d   = StDrain;
        end else if (t_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // For an aborted target this is ARRAY_LATENCY cycles after its last base.
        if (last_sample) begin
          state_d = aborted_q ? StIdle : StReport;
        end
      end
      StReport: begin
        if (score_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    score_valid_d = (state_d == StReport);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      s_q           <= '0;
      t_q           <= '0;
      store_q       <= 1'b0;
      init_q        <= 1'b0;
      q_loaded_q    <= 1'b0;
      pend_q        <= 1'b0;
      err_q         <= 1'b0;
      aborted_q     <= 1'b0;
      score_valid_q <= 1'b0;
      cnt_q         <= '0;
      len_q         <= '0;
      best_q        <= '0;
      best_col_q    <= '0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      t_q           <= t_d;
      store_q       <= store_d;
      init_q        <= init_d;
      q_loaded_q    <= q_loaded_d;
      pend_q        <= pend_d;
      err_q         <= err_d;
      aborted_q     <= aborted_d;
      score_valid_q <= score_valid_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      best_q        <= best_d;
      best_col_q    <= best_col_d;
    end
  end

  assign S_out        = s_q;
  assign T_out        = t_q;
  assign store_S_out  = store_q;
  assign init_out     = init_q;
  assign score_out    = best_q;
  assign score_col    = best_col_q;
  assign score_valid  = score_valid_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_sw_array_sequencer.sv
// Randomized bench for sw_array_sequencer; V_in is driven from a Smith-Waterman DP of the
// loaded query against the streamed target, delayed by the array latency.
module tb_sw_array_sequencer;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int W   = 10;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2*N-1:0]    query_in = '0;
  logic              query_valid = 1'b0;
  logic              query_ready;
  logic [1:0]        t_in = '0;
  logic              t_valid = 1'b0;
  logic              t_last = 1'b0;
  logic              t_ready;
  logic [2*N-1:0]    S_out;
  logic [1:0]        T_out;
  logic              store_S_out;
  logic              init_out;
  logic [W-1:0]      V_in = '0;
  logic [W-1:0]      score_out;
  logic [CW-1:0]     score_col;
  logic              score_valid;
  logic              score_ready = 1'b0;
  logic              err_underrun;

  sw_array_sequencer #(
    .NUM_PES(N), .WIDTH(W), .ARRAY_LATENCY(LAT), .COL_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .query_in(query_in), .query_valid(query_valid), .query_ready(query_ready),
    .t_in(t_in), .t_valid(t_valid), .t_last(t_last), .t_ready(t_ready),
    .S_out(S_out), .T_out(T_out), .store_S_out(store_S_out), .init_out(init_out),
    .V_in(V_in), .score_out(score_out), .score_col(score_col),
    .score_valid(score_valid), .score_ready(score_ready), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference state: what should be presented per cycle and which V the array returns when.
  logic [1:0]     presmap [int];
  logic [W-1:0]   vmap    [int];
  logic [W-1:0]   hrow    [64];
  logic [1:0]     tgt     [64];
  logic [2*N-1:0] cur_q = '0;
  int             initcyc = -1;
  int             storecyc = -1;
  int             kidx = 0;
  bit             next_first = 0;
  bit             pend = 0;
  bit             exp_err = 0;
  logic [W-1:0]   last_score;
  logic [CW-1:0]  last_col;

  always @(negedge clk) begin
    if (query_valid && query_ready) begin
      cur_q = query_in;
      pend  = 1;
    end
    if (t_valid && t_ready) begin
      presmap[cyc+1] = t_in;
      if (next_first) begin
        initcyc = cyc + 1;
        if (pend) storecyc = cyc + 1;
        pend       = 0;
        kidx       = 0;
        next_first = 0;
      end
      vmap[cyc+1+LAT] = hrow[kidx];
      kidx++;
    end
    V_in = vmap.exists(cyc) ? vmap[cyc] : W'($urandom);
    check_eq("t_out", T_out, presmap.exists(cyc) ? presmap[cyc] : 2'd0);
    check_eq("init_out", init_out, cyc == initcyc);
    check_eq("store_S_out", store_S_out, cyc == storecyc);
  end

  // Last-PE score per target column: SW with match +2, mismatch -1, gap -1, floor 0.
  task automatic calc_hrow(input int len);
    int h [0:N][0:64];
    int d, s;
    logic [1:0] qb;
    for (int i = 0; i <= N; i++) for (int j = 0; j <= 64; j++) h[i][j] = 0;
    for (int j = 1; j <= len; j++) begin
      for (int i = 1; i <= N; i++) begin
        qb = cur_q[2*(i-1) +: 2];
        s  = (qb == tgt[j-1]) ? 2 : -1;
        d  = h[i-1][j-1] + s;
        if (h[i-1][j] - 1 > d) d = h[i-1][j] - 1;
        if (h[i][j-1] - 1 > d) d = h[i][j-1] - 1;
        if (d < 0) d = 0;
        h[i][j] = d;
      end
    end
    for (int j = 0; j < len; j++) hrow[j] = W'(h[N][j+1]);
  endtask

  task automatic load_query(input logic [2*N-1:0] q);
    @(posedge clk); #1;
    query_valid = 1; query_in = q;
    @(negedge clk);
    check_eq("load_qready", query_ready, 1);
    check_eq("load_tready", t_ready, 0);
    @(posedge clk); #1;
    query_valid = 0;
    @(negedge clk);
    check_eq("s_out", S_out, q);
  endtask

  task automatic do_target(input bit simul, input logic [2*N-1:0] q, input int len,
                           input int gap_at, input int hold);
    int n;
    bit sv_seen;
    logic [W-1:0] es;
    int ec;
    check_eq("err_sticky", err_underrun, exp_err);
    if (simul) begin
      @(posedge clk); #1;
      query_valid = 1; query_in = q; t_valid = 1; t_in = tgt[0]; t_last = (len == 1);
      @(negedge clk);
      check_eq("simul_qready", query_ready, 1);
      check_eq("simul_tready", t_ready, 0);
      @(posedge clk); #1;
      query_valid = 0;
    end else begin
      @(posedge clk); #1;
    end
    calc_hrow(len);
    next_first = 1;
    es = hrow[0]; ec = 0;
    for (int k = 1; k < len; k++) if (hrow[k] > es) begin es = hrow[k]; ec = k; end

    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        t_valid = 0; t_last = 0;
        exp_err = 1;
        sv_seen = 0;
        @(negedge clk);
        n = 0;
        do begin
          @(negedge clk);
          if (score_valid) sv_seen = 1;
          if (!t_ready) n++;
        end while (!t_ready && n < 100);
        check_eq("flush_cycles", n, LAT);
        check_eq("abort_no_score", sv_seen, 0);
        check_eq("err_underrun", err_underrun, 1);
        return;
      end
      t_valid = 1; t_in = tgt[k]; t_last = (k == len - 1);
      n = 0;
      @(negedge clk);
      while (!t_ready && n < 50) begin n++; @(negedge clk); end
      check_eq("accept_timeout", t_ready, 1);
      @(posedge clk); #1;
    end
    t_valid = 0; t_last = 0;

    n = 0;
    @(negedge clk);
    while (!score_valid && n < LAT + len + 20) begin
      check_eq("drain_tready", t_ready, 0);
      n++;
      @(negedge clk);
    end
    check_eq("report_latency", n, LAT + 1);
    check_eq("score_valid", score_valid, 1);
    check_eq("score_out", score_out, es);
    check_eq("score_col", score_col, ec);
    last_score = score_out;
    last_col   = score_col;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", score_valid, 1);
      check_eq("hold_score", score_out, es);
      check_eq("hold_col", score_col, ec);
      check_eq("hold_tready", t_ready, 0);
    end
    @(posedge clk); #1;
    score_ready = 1;
    @(posedge clk); #1;
    score_ready = 0;
    @(negedge clk);
    check_eq("sv_drop", score_valid, 0);
    check_eq("back_idle", query_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [2*N-1:0] q;
    int len;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_qready", query_ready, 0);
    check_eq("rst_tready", t_ready, 0);
    check_eq("rst_s_out", S_out, 0);
    check_eq("rst_score_valid", score_valid, 0);
    check_eq("rst_score", score_out, 0);
    check_eq("rst_col", score_col, 0);
    check_eq("rst_err", err_underrun, 0);
    rst = 1;
    @(negedge clk);
    check_eq("idle_qready", query_ready, 1);
    check_eq("idle_noquery_tready", t_ready, 0);

    // Query ACGT against target ACGT: four matches ending in column 3.
    tgt[0] = 2'd0; tgt[1] = 2'd1; tgt[2] = 2'd2; tgt[3] = 2'd3;
    load_query(8'hE4);
    do_target(0, '0, 4, -1, 2);
    check_eq("acgt_score", last_score, 8);
    check_eq("acgt_col", last_col, 3);

    // Reuse the loaded query.
    for (int k = 0; k < 4; k++) tgt[k] = 2'd0;
    do_target(0, '0, 4, -1, 0);

    // Query and target offered together.
    q = 8'($urandom);
    for (int k = 0; k < 6; k++) tgt[k] = 2'($urandom_range(0, 3));
    do_target(1, q, 6, -1, 1);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) load_query(8'($urandom));
      len = $urandom_range(2, 20);
      for (int k = 0; k < len; k++) tgt[k] = 2'($urandom_range(0, 3));
      do_target(0, '0, len, -1, $urandom_range(0, 3));
    end

    // Underrun mid-target, then a clean target.
    load_query(8'($urandom));
    for (int k = 0; k < 8; k++) tgt[k] = 2'($urandom_range(0, 3));
    do_target(0, '0, 8, 3, 0);
    for (int k = 0; k < 10; k++) tgt[k] = 2'($urandom_range(0, 3));
    do_target(0, '0, 10, -1, 0);

    // Long backpressure on the result.
    for (int k = 0; k < 7; k++) tgt[k] = 2'($urandom_range(0, 3));
    do_target(1, 8'($urandom), 7, -1, 10);

    // Reset in the middle of a target.
    load_query(8'($urandom));
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) tgt[k] = 2'($urandom_range(0, 3));
    calc_hrow(8);
    next_first = 1;
    t_valid = 1; t_in = tgt[0];
    for (int k = 1; k < 4; k++) begin @(posedge clk); #1; t_in = tgt[k]; end
    rst = 0;
    presmap.delete(); vmap.delete();
    initcyc = -1; storecyc = -1; pend = 0; next_first = 0;
    #1;
    check_eq("mid_rst_qready", query_ready, 0);
    check_eq("mid_rst_tready", t_ready, 0);
    check_eq("mid_rst_s_out", S_out, 0);
    check_eq("mid_rst_t_out", T_out, 0);
    check_eq("mid_rst_init", init_out, 0);
    check_eq("mid_rst_store", store_S_out, 0);
    check_eq("mid_rst_sv", score_valid, 0);
    check_eq("mid_rst_score", score_out, 0);
    check_eq("mid_rst_col", score_col, 0);
    check_eq("mid_rst_err", err_underrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_tready", t_ready, 0);
    end
    t_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
